// File: rtl/mac_sequencer_if.sv
// Signal bundle between the MAC sequencer and its environment: command,
// operand load, MAC datapath control/status, and the result return port.
interface mac_sequencer_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_a_signed;
  logic             cmd_b_signed;

  logic             op_valid;
  logic             op_ready;
  logic [31:0]      op_a;
  logic [31:0]      op_b;

  logic [31:0]      mac_rs1;
  logic [31:0]      mac_rs2;
  logic             mac_rs1_signed;
  logic             mac_rs2_signed;
  logic             mac_start;
  logic             mac_clear;
  logic             mac_valid;
  logic             mac_busy;
  logic [63:0]      mac_result;

  logic             res_valid;
  logic             res_ready;
  logic [63:0]      res_data;
  logic             res_err;

  // The sequencer initiates MAC work, so it takes the master side.
  modport master (
    input  cmd_valid, cmd_len, cmd_a_signed, cmd_b_signed,
    input  op_valid, op_a, op_b,
    input  mac_valid, mac_busy, mac_result,
    input  res_ready,
    output cmd_ready, op_ready,
    output mac_rs1, mac_rs2, mac_rs1_signed, mac_rs2_signed, mac_start, mac_clear,
    output res_valid, res_data, res_err
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_a_signed, cmd_b_signed,
    output op_valid, op_a, op_b,
    output mac_valid, mac_busy, mac_result,
    output res_ready,
    input  cmd_ready, op_ready,
    input  mac_rs1, mac_rs2, mac_rs1_signed, mac_rs2_signed, mac_start, mac_clear,
    input  res_valid, res_data, res_err
  );
endinterface

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: buffers operand pairs, clears the MAC accumulator,
// issues each pair with a start pulse and returns the settled 64-bit sum.
module mac_sequencer #(
  parameter int DEPTH   = 16,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  mac_sequencer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ISSUE, S_WAIT, S_SETTLE, S_DONE, S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    pair_q, pair_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                a_sgn_q, a_sgn_d;
  logic                b_sgn_q, b_sgn_d;
  logic [31:0]         rs1_q, rs1_d;
  logic [31:0]         rs2_q, rs2_d;
  logic [63:0]         res_data_q, res_data_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DEPTH-1:0][63:0] mem_q;

  logic                push, pop, flush, full, empty, start;
  logic [LEN_W-1:0]    pair_inc;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign start    = (state_q == S_WAIT) && (timer_q == '0);
  assign flush    = (state_q == S_ERR) && bus.res_ready;
  // A push landing in the flush cycle is dropped along with the queue.
  assign push     = bus.op_valid && !full && !flush;
  assign pair_inc = pair_q + LEN_W'(1);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    pair_d     = pair_q;
    timer_d    = timer_q;
    a_sgn_d    = a_sgn_q;
    b_sgn_d    = b_sgn_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    res_data_d = res_data_q;
    pop        = 1'b0;

    unique case (state_q)
      S_IDLE: if (bus.cmd_valid) begin
        len_d   = bus.cmd_len;
        a_sgn_d = bus.cmd_a_signed;
        b_sgn_d = bus.cmd_b_signed;
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        pair_d  = '0;
        state_d = (len_q == '0) ? S_SETTLE : S_ISSUE;
      end
      S_ISSUE: if (!empty && !bus.mac_busy) begin
        pop     = 1'b1;
        rs1_d   = mem_q[rd_ptr_q][63:32];
        rs2_d   = mem_q[rd_ptr_q][31:0];
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // mac_valid during the start cycle belongs to no pair of ours.
        if (bus.mac_valid && !start) begin
          pair_d  = pair_inc;
          state_d = (pair_inc == len_q) ? S_SETTLE : S_ISSUE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          res_data_d = bus.mac_result;
          state_d    = S_ERR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_SETTLE: begin
        res_data_d = bus.mac_result;
        state_d    = S_DONE;
      end
      S_DONE: if (bus.res_ready) state_d = S_IDLE;
      S_ERR:  if (bus.res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + (push ? AW'(1) : AW'(0));
    rd_ptr_d = rd_ptr_q + (pop  ? AW'(1) : AW'(0));
    cnt_d    = cnt_q + (push ? CW'(1) : CW'(0)) - (pop ? CW'(1) : CW'(0));
    if (flush) begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = wr_ptr_q;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      pair_q     <= '0;
      timer_q    <= '0;
      a_sgn_q    <= 1'b0;
      b_sgn_q    <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      res_data_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      pair_q     <= pair_d;
      timer_q    <= timer_d;
      a_sgn_q    <= a_sgn_d;
      b_sgn_q    <= b_sgn_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      res_data_q <= res_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Storage needs no reset: only entries counted by cnt_q are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.op_a, bus.op_b};
  end

  assign bus.cmd_ready      = (state_q == S_IDLE);
  assign bus.op_ready       = !full;
  assign bus.mac_rs1        = rs1_q;
  assign bus.mac_rs2        = rs2_q;
  assign bus.mac_rs1_signed = a_sgn_q;
  assign bus.mac_rs2_signed = b_sgn_q;
  assign bus.mac_start      = start;
  assign bus.mac_clear      = (state_q == S_CLEAR);
  assign bus.res_valid      = (state_q == S_DONE) || (state_q == S_ERR);
  assign bus.res_err        = (state_q == S_ERR);
  assign bus.res_data       = res_data_q;
endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a small behavioural MAC attached.
module tb_mac_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mac_sequencer_if #(.LEN_W(8)) bus();

  mac_sequencer #(.DEPTH(16), .LEN_W(8), .TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural MAC: fixed latency after start, accumulates on mac_valid.
  logic [63:0] acc_q = '0;
  logic [31:0] ma_q = '0, mb_q = '0;
  logic        msa_q = 1'b0, msb_q = 1'b0, busy_q = 1'b0, dead = 1'b0;
  logic [1:0]  lat_q = '0;
  logic [63:0] ea, eb, prod;
  assign ea   = msa_q ? {{32{ma_q[31]}}, ma_q} : {32'b0, ma_q};
  assign eb   = msb_q ? {{32{mb_q[31]}}, mb_q} : {32'b0, mb_q};
  assign prod = ea * eb;

  always @(posedge clk) begin
    if (!rst || bus.mac_clear) begin
      acc_q  <= '0;
      busy_q <= 1'b0;
      lat_q  <= '0;
    end else if (bus.mac_start) begin
      busy_q <= 1'b1;
      lat_q  <= 2'd2;
      ma_q   <= bus.mac_rs1;
      mb_q   <= bus.mac_rs2;
      msa_q  <= bus.mac_rs1_signed;
      msb_q  <= bus.mac_rs2_signed;
    end else if (busy_q) begin
      if (lat_q != 2'd0) lat_q <= lat_q - 2'd1;
      else if (!dead) begin
        acc_q  <= acc_q + prod;
        busy_q <= 1'b0;
      end
    end
  end
  assign bus.mac_valid  = busy_q && (lat_q == 2'd0) && !dead;
  assign bus.mac_busy   = busy_q;
  assign bus.mac_result = acc_q;

  int n_start = 0, n_clear = 0;
  always @(posedge clk) begin
    if (bus.mac_start) n_start <= n_start + 1;
    if (bus.mac_clear) n_clear <= n_clear + 1;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = 1'b1; bus.op_a = a; bus.op_b = b;
    step();
    bus.op_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] len, input logic sa, input logic sb);
    int n = 0;
    while (!bus.cmd_ready && n < 200) begin step(); n++; end
    chk("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1; bus.cmd_len = len;
    bus.cmd_a_signed = sa; bus.cmd_b_signed = sb;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, output int n);
    n = 0;
    while (!bus.res_valid && n < 300) begin step(); n++; end
    chk(tag, 64'(bus.res_valid), 64'd1);
  endtask

  task automatic take();
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
  endtask

  // Issue a len=1 job with nothing queued: it must not start (FIFO empty).
  task automatic stall_check(input string tag);
    int s0;
    send_cmd(8'd1, 1'b0, 1'b0);
    s0 = n_start;
    repeat (20) step();
    chk({tag, "_nostart"}, 64'(n_start - s0), 64'd0);
    chk({tag, "_novalid"}, 64'(bus.res_valid), 64'd0);
  endtask

  initial begin
    int n, s0, c0;
    bus.cmd_valid = 0; bus.cmd_len = '0; bus.cmd_a_signed = 0; bus.cmd_b_signed = 0;
    bus.op_valid = 0; bus.op_a = '0; bus.op_b = '0; bus.res_ready = 0;

    // Reset state
    rst = 1'b0;
    step(); step();
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_op_ready",  64'(bus.op_ready),  64'd1);
    chk("rst_start",     64'(bus.mac_start), 64'd0);
    chk("rst_clear",     64'(bus.mac_clear), 64'd0);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_res_data",  bus.res_data,       64'd0);
    rst = 1'b1;
    step();

    // Signed dot product: 6 - 20 - 7 = -21
    push(32'd2, 32'd3);
    push(-32'sd4, 32'd5);
    push(32'd7, -32'sd1);
    s0 = n_start; c0 = n_clear;
    send_cmd(8'd3, 1'b1, 1'b1);
    wait_res("dot_wait", n);
    chk("dot_data",   bus.res_data,           64'hFFFF_FFFF_FFFF_FFEB);
    chk("dot_err",    64'(bus.res_err),       64'd0);
    chk("dot_starts", 64'(n_start - s0),      64'd3);
    chk("dot_clears", 64'(n_clear - c0),      64'd1);
    take();
    chk("dot_idle_valid", 64'(bus.res_valid), 64'd0);

    // Unsigned single pair
    push(32'hFFFF_FFFF, 32'd2);
    send_cmd(8'd1, 1'b0, 1'b0);
    wait_res("uns_wait", n);
    chk("uns_data", bus.res_data, 64'h0000_0001_FFFF_FFFE);
    take();

    // len=0: clear only, result three cycles after accept
    s0 = n_start; c0 = n_clear;
    send_cmd(8'd0, 1'b0, 1'b0);
    chk("len0_clear_pulse", 64'(bus.mac_clear), 64'd1);
    step();
    chk("len0_settle_novalid", 64'(bus.res_valid), 64'd0);
    step();
    chk("len0_valid",  64'(bus.res_valid), 64'd1);
    chk("len0_data",   bus.res_data,       64'd0);
    chk("len0_starts", 64'(n_start - s0),  64'd0);
    chk("len0_clears", 64'(n_clear - c0),  64'd1);
    take();

    // FIFO full with 16 pairs; 17th held off until the first pop
    for (int i = 0; i < 16; i++) begin
      push(32'd1, 32'd1);
      if (i == 14) chk("fifo_15_ready", 64'(bus.op_ready), 64'd1);
    end
    chk("fifo_full_ready", 64'(bus.op_ready), 64'd0);
    bus.op_valid = 1'b1; bus.op_a = 32'd1; bus.op_b = 32'd1;
    step(); step();
    chk("fifo_17_held", 64'(bus.op_ready), 64'd0);
    send_cmd(8'd16, 1'b0, 1'b0);
    n = 0;
    while (!bus.op_ready && n < 50) begin step(); n++; end
    chk("fifo_ready_back",     64'(bus.op_ready),  64'd1);
    chk("fifo_ready_at_start", 64'(bus.mac_start), 64'd1);
    step();
    bus.op_valid = 1'b0;
    wait_res("fifo16_wait", n);
    chk("fifo16_data", bus.res_data, 64'd16);
    take();
    send_cmd(8'd1, 1'b0, 1'b0);
    wait_res("fifo17_wait", n);
    chk("fifo17_data", bus.res_data, 64'd1);
    take();

    // Timeout: MAC never answers
    dead = 1'b1;
    push(32'd5, 32'd6);
    push(32'd7, 32'd8);
    send_cmd(8'd2, 1'b0, 1'b0);
    wait_res("to_wait", n);
    chk("to_latency",   64'(n),            64'd66);
    chk("to_err",       64'(bus.res_err),  64'd1);
    chk("to_data",      bus.res_data,      64'd0);
    chk("to_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    bus.op_valid = 1'b1; bus.op_a = 32'd9; bus.op_b = 32'd9;
    take();
    bus.op_valid = 1'b0;
    chk("to_idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("to_idle_op_ready",  64'(bus.op_ready),  64'd1);
    dead = 1'b0;
    stall_check("to_flush");
    push(32'd3, 32'd4);
    wait_res("to_after_wait", n);
    chk("to_after_data", bus.res_data, 64'd12);
    take();

    // Backpressure: result held, commands refused
    push(32'd2, 32'd2);
    send_cmd(8'd1, 1'b0, 1'b0);
    wait_res("bp_wait", n);
    bus.cmd_valid = 1'b1; bus.cmd_len = 8'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid",     64'(bus.res_valid), 64'd1);
      chk("bp_data",      bus.res_data,       64'd4);
      chk("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    end
    bus.cmd_valid = 1'b0;
    take();

    // Reset in the middle of WAIT
    push(32'd9, 32'd9);
    push(32'd1, 32'd1);
    send_cmd(8'd2, 1'b1, 1'b1);
    n = 0;
    while (!bus.mac_start && n < 50) begin step(); n++; end
    chk("mr_started", 64'(bus.mac_start), 64'd1);
    step();
    chk("mr_rs1_held", 64'(bus.mac_rs1), 64'd9);
    rst = 1'b0;
    step();
    chk("mr_start",     64'(bus.mac_start),      64'd0);
    chk("mr_clear",     64'(bus.mac_clear),      64'd0);
    chk("mr_res_valid", 64'(bus.res_valid),      64'd0);
    chk("mr_res_err",   64'(bus.res_err),        64'd0);
    chk("mr_res_data",  bus.res_data,            64'd0);
    chk("mr_rs1",       64'(bus.mac_rs1),        64'd0);
    chk("mr_rs2",       64'(bus.mac_rs2),        64'd0);
    chk("mr_rs1_sgn",   64'(bus.mac_rs1_signed), 64'd0);
    chk("mr_rs2_sgn",   64'(bus.mac_rs2_signed), 64'd0);
    chk("mr_cmd_ready", 64'(bus.cmd_ready),      64'd1);
    chk("mr_op_ready",  64'(bus.op_ready),       64'd1);
    rst = 1'b1;
    step();
    stall_check("mr_fifo");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
